// File: rtl/mic_pkg.sv
// ---------------------------------------------------------------------------
// mic_pkg
// Shared constants for the PDM microphone decimator slice.
//   CLK_DIV_DEF      clk_100MHz cycles per micClk period (3.125 MHz)
//   SAMPLE_PHASE_DEF divider count at which the synchronized PDM bit is taken
//   DECIM_DEF        PDM bits accumulated per PCM sample (48.828 kHz)
//   GAIN_SHIFT_DEF   left shift applied to the centred ones-count
//   PCM_W            PCM sample width
//   DIV_W / CNT_W    widths of the divider counter and ones counter at defaults
// ---------------------------------------------------------------------------
package mic_pkg;

  localparam int CLK_DIV_DEF      = 32;
  localparam int SAMPLE_PHASE_DEF = 31;
  localparam int DECIM_DEF        = 64;
  localparam int GAIN_SHIFT_DEF   = 8;

  localparam int PCM_W = 16;
  localparam int DIV_W = $clog2(CLK_DIV_DEF);
  localparam int CNT_W = $clog2(DECIM_DEF + 1);

endpackage

// File: rtl/pdm_clk_gen.sv
// ---------------------------------------------------------------------------
// pdm_clk_gen
// Divides clk_100MHz down to the microphone clock and produces a one-cycle
// strobe at the divider phase where the synchronized PDM bit is valid.
// Ports:
//   clk_100MHz  in   system clock
//   sysreset_n  in   asynchronous active-low reset
//   enable      in   run the divider; low holds it at zero with micClk low
//   micClk      out  registered microphone clock, 50% duty, period CLK_DIV
//   sampleStb   out  one-cycle strobe while the divider sits at SAMPLE_PHASE
// ---------------------------------------------------------------------------
module pdm_clk_gen
  import mic_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int SAMPLE_PHASE = SAMPLE_PHASE_DEF
) (
  input  logic clk_100MHz,
  input  logic sysreset_n,
  input  logic enable,
  output logic micClk,
  output logic sampleStb
);

  localparam int DivW = $clog2(CLK_DIV);

  // An odd or tiny divider cannot give an exact 50% duty, and a sample
  // phase outside the count range would never strobe.
  if ((CLK_DIV < 4) || ((CLK_DIV % 2) != 0)) begin : gBadDiv
    $error("pdm_clk_gen: CLK_DIV must be even and at least 4");
  end
  if ((SAMPLE_PHASE < 0) || (SAMPLE_PHASE >= CLK_DIV)) begin : gBadPhase
    $error("pdm_clk_gen: SAMPLE_PHASE must lie in 0..CLK_DIV-1");
  end

  logic [DivW-1:0] divCnt;

  // Divider and microphone clock. micClk is registered from the count so it
  // is high for counts 0..CLK_DIV/2-1 and low for the rest of the period.
  // Disabling parks the count at zero so that re-enabling always starts a
  // fresh period with micClk high.
  always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
    if (!sysreset_n) begin
      divCnt <= '0;
      micClk <= 1'b0;
    end else if (!enable) begin
      divCnt <= '0;
      micClk <= 1'b0;
    end else begin
      divCnt <= (divCnt == DivW'(CLK_DIV - 1)) ? '0 : divCnt + DivW'(1);
      micClk <= (divCnt < DivW'(CLK_DIV / 2));
    end
  end

  // The strobe is gated by enable so a disabled divider never samples, even
  // when SAMPLE_PHASE happens to be zero.
  assign sampleStb = enable && (divCnt == DivW'(SAMPLE_PHASE));

endmodule

// File: rtl/pdm_mic_decimator.sv
// ---------------------------------------------------------------------------
// pdm_mic_decimator
// Converts the synchronized 1-bit PDM microphone stream into signed 16-bit
// PCM with an accumulate-and-dump decimator and hands samples out over a
// valid/ready interface with a sticky overrun flag.
// Ports:
//   clk_100MHz    in   system clock, 100 MHz
//   sysreset_n    in   asynchronous active-low reset
//   enable        in   run decimator and micClk; low = idle
//   micData_sync  in   synchronized PDM data
//   micClk        out  microphone clock, registered
//   pcm_data      out  signed two's-complement PCM sample
//   pcm_valid     out  pcm_data holds an undelivered sample
//   pcm_ready     in   consumer takes pcm_data when pcm_valid & pcm_ready
//   overrun       out  sticky: an undelivered sample was overwritten
//   overrun_clr   in   single-cycle clear of overrun
// ---------------------------------------------------------------------------
module pdm_mic_decimator
  import mic_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  parameter int DECIM        = DECIM_DEF,
  parameter int GAIN_SHIFT   = GAIN_SHIFT_DEF
) (
  input  logic             clk_100MHz,
  input  logic             sysreset_n,
  input  logic             enable,
  input  logic             micData_sync,
  output logic             micClk,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int CntW = $clog2(DECIM + 1);
  localparam int BitW = $clog2(DECIM);

  // The full-scale centred count must still fit a positive 16-bit sample.
  if ((DECIM < 2) || ((DECIM << GAIN_SHIFT) > 32767)) begin : gBadGain
    $error("pdm_mic_decimator: DECIM << GAIN_SHIFT must not exceed 32767");
  end

  logic             sampleStb;
  logic             lastBit;
  logic             newSample;
  logic             overrunSet;
  logic [BitW-1:0]  bitCnt;
  logic [CntW-1:0]  onesCnt;
  logic [CntW-1:0]  total;
  logic [16:0]      centred;
  logic [PCM_W-1:0] pcmNext;

  pdm_clk_gen #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) uClkGen (
    .clk_100MHz (clk_100MHz),
    .sysreset_n (sysreset_n),
    .enable     (enable),
    .micClk     (micClk),
    .sampleStb  (sampleStb)
  );

  // Running total including the bit being strobed now, so the final strobe
  // of a window contributes without an extra cycle of latency. Centring is
  // done in 17 bits so +DECIM shifted up cannot wrap before truncation.
  assign lastBit    = (bitCnt == BitW'(DECIM - 1));
  assign newSample  = sampleStb && lastBit;
  assign total      = onesCnt + CntW'(micData_sync);
  assign centred    = 17'({total, 1'b0}) - 17'(DECIM);
  assign pcmNext    = PCM_W'(centred << GAIN_SHIFT);
  assign overrunSet = newSample && pcm_valid && !pcm_ready;

  // Boxcar accumulator. Dropping enable discards any partial window, so a
  // sample is only ever built from DECIM consecutive enabled strobes.
  always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
    if (!sysreset_n) begin
      bitCnt  <= '0;
      onesCnt <= '0;
    end else if (!enable) begin
      bitCnt  <= '0;
      onesCnt <= '0;
    end else if (sampleStb) begin
      bitCnt  <= lastBit ? '0 : bitCnt + BitW'(1);
      onesCnt <= lastBit ? '0 : total;
    end
  end

  // Output register and handshake. A new sample always loads; if the
  // previous one is still pending and not being taken this cycle it is lost
  // and overrun latches. Setting overrun takes priority over a clear in the
  // same cycle. This logic ignores enable so a pending sample can drain.
  always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
    if (!sysreset_n) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (newSample) begin
        pcm_data  <= pcmNext;
        pcm_valid <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end

      if (overrunSet) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pdm_mic_decimator.md
Name: pdm_mic_decimator

Overview:
Consumes the synchronized on-board microphone PDM bitstream (micData_sync, already 3-stage synchronized upstream) and generates the microphone clock micClk. Converts 1-bit PDM to signed 16-bit PCM with an accumulate-and-dump (boxcar) decimator. Delivers samples to the embedded system over a valid/ready handshake and flags lost samples with a sticky overrun bit. Sits between the top-level microphone synchronizer and the EMBSYS audio/processing path.

Parameters:
CLK_DIV, 32, clk_100MHz cycles per micClk period; even, >=4; default gives 3.125 MHz
SAMPLE_PHASE, 31, div_cnt value at which micData_sync is sampled; covers mic output delay plus the 3-cycle synchronizer
DECIM, 64, PDM bits per PCM sample; default gives 48.828 kHz
GAIN_SHIFT, 8, left shift applied to the centred ones-count; elaboration error if DECIM<<GAIN_SHIFT > 32767

Ports:
clk_100MHz  in  1  system clock, 100 MHz
sysreset_n  in  1  asynchronous active-low reset
enable  in  1  run decimator and micClk; low = idle
micData_sync  in  1  synchronized PDM data
micClk  out  1  microphone clock, registered
pcm_data  out  16  signed two's-complement PCM sample
pcm_valid  out  1  pcm_data holds an undelivered sample
pcm_ready  in  1  consumer accepts pcm_data when pcm_valid & pcm_ready
overrun  out  1  sticky: an undelivered sample was overwritten
overrun_clr  in  1  single-cycle clear of overrun

Behaviour:
- Reset (async assert, sync release): div_cnt=0, bit_cnt=0, ones=0, micClk=0, pcm_data=0, pcm_valid=0, overrun=0.
- div_cnt counts 0..CLK_DIV-1 and wraps. micClk is registered high while div_cnt in [0, CLK_DIV/2-1], low otherwise: exact 50% duty, period CLK_DIV.
- sample_stb is asserted for one cycle when div_cnt==SAMPLE_PHASE. On sample_stb: ones += micData_sync; bit_cnt++.
- On the sample_stb where bit_cnt==DECIM-1: total = ones + micData_sync. pcm_data <= (2*total - DECIM) <<< GAIN_SHIFT, sign-extended to 16 bits. ones <= 0, bit_cnt <= 0. pcm_valid <= 1 on the next cycle (latency 1 clock from the final strobe).
- Defaults: range -64..+64, giving pcm_data -16384..+16384 (0xC000..0x4000).
- Handshake: transfer occurs when pcm_valid & pcm_ready. After a transfer with no new sample that cycle, pcm_valid <= 0. pcm_data is stable while pcm_valid=1 except on an overwrite.
- New sample with pcm_valid=1 & pcm_ready=1 in the same cycle: old sample transfers, new sample loads, pcm_valid stays 1, no overrun.
- New sample with pcm_valid=1 & pcm_ready=0: new sample overwrites, overrun <= 1.
- overrun_clr and an overrun set in the same cycle: set wins. Otherwise overrun_clr clears overrun.
- enable=0: div_cnt, bit_cnt and ones are held at 0; micClk=0; no strobes. pcm_valid, pcm_data and overrun are unaffected, so a pending sample can still be drained.
- enable rising: counting restarts from div_cnt=0 (micClk high on the first enabled cycle). The first sample uses a full DECIM bits. No partial sample is ever emitted.
- Reset mid-sample: partial accumulation is discarded and outputs return to reset values immediately.
- Width: ones is clog2(DECIM+1) bits. Intermediate arithmetic is 17-bit signed to avoid overflow at the +DECIM extreme.

Decomposition:
- Shared package mic_pkg: default CLK_DIV, DECIM, GAIN_SHIFT and SAMPLE_PHASE constants; PCM_W=16; derived widths DIV_W and CNT_W.
- Sub-module pdm_clk_gen: div_cnt, registered micClk and sample_stb, gated by enable.
- Top of this block: accumulator, scaling, output register, handshake and overrun logic.

Test Plan:
- Reset, then enable=1 with micData_sync held at 1 and pcm_ready=1 -> micClk period 32 cycles, 16 high; first pcm_valid pulse with pcm_data=0x4000 on the cycle after the 64th strobe (about 2048 cycles after enable); valid pulses every 2048 cycles.
- micData_sync constant 0 -> pcm_data=0xC000. Alternating 1/0 per strobe -> pcm_data=0x0000. 48 ones then 16 zeros -> 0x2000.
- pcm_ready=0 across two sample periods -> first sample held with pcm_valid=1, second overwrites, overrun=1. Pulse overrun_clr -> overrun=0. Assert overrun_clr on the same cycle as a third overwrite -> overrun stays 1.
- pcm_ready rises on the exact cycle a new sample completes -> old value transfers, new value loads, pcm_valid stays 1, overrun stays 0.
- Drop enable at bit 30 of a sample, hold 100 cycles, re-raise -> micClk=0 while disabled, no sample emitted; the next sample reflects exactly 64 fresh bits. A pending valid sample is still delivered while disabled.
- Assert sysreset_n=0 asynchronously mid-sample with pcm_valid=1 -> all outputs 0 without waiting for a clock edge; after release, the first sample arrives after a full 64 strobes.
